// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared state encodings and command codes for the scanner
package scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STANDBY  = 2'd2,
        ST_TRANSFER = 2'd3
    } state_t;

    localparam logic [2:0] CMD_READY = 3'd2;
    localparam logic [2:0] CMD_START = 3'd3;
    localparam logic [2:0] CMD_FULL  = 3'd4;
    localparam logic [2:0] CMD_DATA  = 3'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_serializer.sv
// rtl/scan_serializer.sv - LSB-first word shifter with frame qualifier
// A word loaded with last=0 releases busy on its final bit so the next word follows gaplessly.
module scan_serializer #(
    parameter int MAX_W = 8,
    parameter int LEN_W = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [MAX_W-1:0] word,
    input  logic [LEN_W-1:0] len,
    input  logic             last,
    output logic             busy,
    output logic             ser_en,
    output logic             ser_data,
    output logic             ser_frame
);

    logic             active;
    logic             last_r;
    logic [MAX_W-1:0] sh;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            last_r <= 1'b0;
            sh     <= '0;
            cnt    <= '0;
        end else if (flush) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            last_r <= last;
            sh     <= word;
            cnt    <= len;
        end else if (active) begin
            if (cnt == LEN_W'(1)) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                sh  <= sh >> 1;
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

    assign busy      = active && !(cnt == LEN_W'(1) && !last_r);
    assign ser_en    = active;
    assign ser_frame = active;
    assign ser_data  = active & sh[0];

endmodule

// File: rtl/scanner_gen2.sv
// rtl/scanner_gen2.sv - buffered scanner with fill-level commands and serial burst transfer
module scanner_gen2
    import scanner_pkg::*;
#(
    parameter int DEPTH     = 10,
    parameter int DATA_W    = 8,
    parameter int CMD_W     = 8,
    parameter int READY_LVL = 7,
    parameter int START_LVL = 8,
    parameter int SLOW_DIV  = 8,
    parameter int FAKE_DATA = 1,
    localparam int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_scan,
    input  logic              peer_half,
    input  logic              ready_for_transfer_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              ser_en,
    output logic              ser_data,
    output logic              ser_frame,
    output logic [1:0]        state,
    output logic [FW-1:0]     fill,
    output logic              done_pulse
);

    localparam int MAX_W = max_int(CMD_W, DATA_W);
    localparam int LW    = $clog2(MAX_W + 1);
    localparam int DW    = $clog2(SLOW_DIV);
    localparam int IW    = $clog2(DEPTH);
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
    localparam logic [FW-1:0] START_F = FW'(START_LVL);
    localparam logic [FW-1:0] READY_F = FW'(READY_LVL);

    state_t            st, st_nxt;
    logic [DW-1:0]     div;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     rptr;
    logic              pend_v, full_sent, cmd_sent, data_all;
    logic [2:0]        pend_code, lvl_code;
    logic              lvl_hit, tick, wr_en, last_word;
    logic              launch_cmd, load_dcmd, load_word, xfer_done, flush;
    logic              ser_busy, ser_load, ser_last;
    logic [MAX_W-1:0]  ser_word;
    logic [LW-1:0]     ser_len;
    logic [FW-1:0]     fill_inc;

    assign tick      = (st == ST_ACTIVE) && (div == DW'(SLOW_DIV - 1));
    assign wr_en     = (st == ST_ACTIVE) && (fill != DEPTH_F) &&
                       ((FAKE_DATA != 0) ? tick : sample_valid);
    assign fill_inc  = fill + FW'(1);
    assign last_word = (FW'(rptr) == fill - FW'(1));

    assign launch_cmd = (st == ST_ACTIVE) && pend_v && !ser_busy;
    assign flush      = (st == ST_TRANSFER) && peer_half;
    assign load_dcmd  = (st == ST_TRANSFER) && !peer_half && !cmd_sent && !ser_busy;
    assign load_word  = (st == ST_TRANSFER) && !peer_half && cmd_sent && !data_all && !ser_busy;
    assign xfer_done  = (st == ST_TRANSFER) && !peer_half && cmd_sent && data_all && !ser_busy;

    // Highest level reached wins, so a newer crossing overwrites a pending lower command.
    always_comb begin
        lvl_hit  = 1'b0;
        lvl_code = CMD_READY;
        if (fill_inc == DEPTH_F) begin
            lvl_hit  = 1'b1;
            lvl_code = CMD_FULL;
        end else if (fill_inc == START_F) begin
            lvl_hit  = 1'b1;
            lvl_code = CMD_START;
        end else if (fill_inc == READY_F) begin
            lvl_hit  = 1'b1;
            lvl_code = CMD_READY;
        end
    end

    always_comb begin
        ser_load = 1'b0;
        ser_word = '0;
        ser_len  = '0;
        ser_last = 1'b0;
        if (launch_cmd) begin
            ser_load = 1'b1;
            ser_word = MAX_W'(CMD_W'(pend_code));
            ser_len  = LW'(CMD_W);
            ser_last = 1'b1;
        end else if (load_dcmd) begin
            ser_load = 1'b1;
            ser_word = MAX_W'(CMD_W'(CMD_DATA));
            ser_len  = LW'(CMD_W);
        end else if (load_word) begin
            ser_load = 1'b1;
            ser_word = MAX_W'(mem[rptr]);
            ser_len  = LW'(DATA_W);
            ser_last = last_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_IDLE;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:     if (start_scan) st_nxt = ST_ACTIVE;
            ST_ACTIVE:   if (full_sent) st_nxt = ready_for_transfer_in ? ST_TRANSFER : ST_STANDBY;
            ST_STANDBY:  if (ready_for_transfer_in || peer_half) st_nxt = ST_TRANSFER;
            ST_TRANSFER: if (flush || xfer_done) st_nxt = ST_IDLE;
            default:     st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div        <= '0;
            fill       <= '0;
            rptr       <= '0;
            pend_v     <= 1'b0;
            pend_code  <= '0;
            full_sent  <= 1'b0;
            cmd_sent   <= 1'b0;
            data_all   <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= xfer_done;
            div        <= (st == ST_ACTIVE && !tick) ? div + DW'(1) : '0;
            if (st == ST_IDLE && start_scan) begin
                fill      <= '0;
                rptr      <= '0;
                pend_v    <= 1'b0;
                full_sent <= 1'b0;
                cmd_sent  <= 1'b0;
                data_all  <= 1'b0;
            end
            if (launch_cmd) begin
                pend_v <= 1'b0;
                if (pend_code == CMD_FULL) full_sent <= 1'b1;
            end
            if (wr_en) begin
                fill <= fill_inc;
                if (lvl_hit) begin
                    pend_v    <= 1'b1;
                    pend_code <= lvl_code;
                end
            end
            if (load_dcmd) cmd_sent <= 1'b1;
            if (load_word) begin
                if (last_word) data_all <= 1'b1;
                else           rptr     <= rptr + IW'(1);
            end
            if (flush || xfer_done) begin
                fill     <= '0;
                rptr     <= '0;
                cmd_sent <= 1'b0;
                data_all <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[fill[IW-1:0]] <= (FAKE_DATA != 0) ? DATA_W'(fill) : sample_data;
    end

    scan_serializer #(.MAX_W(MAX_W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .flush     (flush),
        .word      (ser_word),
        .len       (ser_len),
        .last      (ser_last),
        .busy      (ser_busy),
        .ser_en    (ser_en),
        .ser_data  (ser_data),
        .ser_frame (ser_frame)
    );

    assign state = st;

endmodule

// File: tb/tb_scanner_gen2.sv
// tb/tb_scanner_gen2.sv - directed self-checking bench for scanner_gen2
module tb_scanner_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, peer_a, rdy_a, sv_a;
    logic [7:0] sd_a;
    logic       en_a, dat_a, frm_a, done_a;
    logic [1:0] state_a;
    logic [3:0] fill_a;
    logic       start_b, peer_b, rdy_b, sv_b;
    logic [7:0] sd_b;
    logic       en_b, dat_b, frm_b, done_b;
    logic [1:0] state_b;
    logic [2:0] fill_b;

    int n_checks = 0;
    int n_fail   = 0;

    bit bits_a[$];
    bit bits_b[$];
    int flen_a[$];
    int flen_b[$];
    int cur_a = 0, cur_b = 0, dones_a = 0, dones_b = 0;

    always #5 clk = ~clk;

    scanner_gen2 dut_a (
        .clk(clk), .rst(rst), .start_scan(start_a), .peer_half(peer_a),
        .ready_for_transfer_in(rdy_a), .sample_valid(sv_a), .sample_data(sd_a),
        .ser_en(en_a), .ser_data(dat_a), .ser_frame(frm_a),
        .state(state_a), .fill(fill_a), .done_pulse(done_a)
    );

    scanner_gen2 #(.DEPTH(4), .READY_LVL(2), .START_LVL(3), .SLOW_DIV(2), .FAKE_DATA(0)) dut_b (
        .clk(clk), .rst(rst), .start_scan(start_b), .peer_half(peer_b),
        .ready_for_transfer_in(rdy_b), .sample_valid(sv_b), .sample_data(sd_b),
        .ser_en(en_b), .ser_data(dat_b), .ser_frame(frm_b),
        .state(state_b), .fill(fill_b), .done_pulse(done_b)
    );

    // Frame receiver: collects bits while ser_frame is high, logs frame lengths on its fall.
    always @(negedge clk) begin
        if (frm_a) begin bits_a.push_back(dat_a); cur_a++; end
        else if (cur_a > 0) begin flen_a.push_back(cur_a); cur_a = 0; end
        if (frm_b) begin bits_b.push_back(dat_b); cur_b++; end
        else if (cur_b > 0) begin flen_b.push_back(cur_b); cur_b = 0; end
        if (done_a) dones_a++;
        if (done_b) dones_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_a(input int pos, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            if (pos + i < bits_a.size() && bits_a[pos + i]) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] word_b(input int pos, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            if (pos + i < bits_b.size() && bits_b[pos + i]) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state_a(input logic [1:0] s, input int lim, input string tag);
        for (int i = 0; i < lim && state_a !== s; i++) tick();
        check(tag, state_a, s);
    endtask

    task automatic wait_state_b(input logic [1:0] s, input int lim, input string tag);
        for (int i = 0; i < lim && state_b !== s; i++) tick();
        check(tag, state_b, s);
    endtask

    task automatic scan_full_a(input string tag);
        int fb = flen_a.size();
        int bb = bits_a.size();
        int d0 = dones_a;
        int pos;
        rdy_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 600 && dones_a == d0; i++) tick();
        repeat (3) tick();
        check({tag, "_done_cnt"}, dones_a - d0, 1);
        check({tag, "_state"}, state_a, 0);
        check({tag, "_fill"}, fill_a, 0);
        check({tag, "_frames"}, flen_a.size() - fb, 4);
        if (flen_a.size() - fb >= 4) begin
            check({tag, "_len0"}, flen_a[fb], 8);
            check({tag, "_len3"}, flen_a[fb + 3], 88);
            pos = bb;
            check({tag, "_cmd_ready"}, word_a(pos, 8), 2);  pos += 8;
            check({tag, "_cmd_start"}, word_a(pos, 8), 3);  pos += 8;
            check({tag, "_cmd_full"},  word_a(pos, 8), 4);  pos += 8;
            check({tag, "_cmd_data"},  word_a(pos, 8), 7);  pos += 8;
            for (int w = 0; w < 10; w++) begin
                check($sformatf("%s_word%0d", tag, w), word_a(pos, 8), w);
                pos += 8;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog state_a=%0d state_b=%0d", state_a, state_b);
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, bb, d0, pos;
        logic [7:0] vals [5];
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF; vals[3] = 8'h01; vals[4] = 8'h77;
        rst = 1'b0;
        start_a = 0; peer_a = 0; rdy_a = 0; sv_a = 0; sd_a = 0;
        start_b = 0; peer_b = 0; rdy_b = 0; sv_b = 0; sd_b = 0;
        repeat (3) tick();
        check("rst_state", state_a, 0);
        check("rst_fill", fill_a, 0);
        check("rst_ser", {en_a, dat_a, frm_a, done_a}, 0);
        rst = 1'b1;
        tick();

        // full scan with transfer granted at full
        scan_full_a("t1");

        // peer not ready: hold in STANDBY, peer_half forces the transfer
        fb = flen_a.size(); d0 = dones_a;
        rdy_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_state_a(2, 400, "t2_standby");
        repeat (20) tick();
        check("t2_standby_hold", state_a, 2);
        check("t2_cmd_frames", flen_a.size() - fb, 3);
        peer_a = 1'b1;
        tick();
        check("t2_to_transfer", state_a, 3);
        peer_a = 1'b0;
        tick();
        check("t2_cmd7_frame", frm_a, 1);
        check("t2_cmd7_bit0", dat_a, 1);
        for (int i = 0; i < 300 && dones_a == d0; i++) tick();
        repeat (2) tick();
        check("t2_done", dones_a - d0, 1);
        check("t2_frames", flen_a.size() - fb, 4);
        if (flen_a.size() - fb >= 4) check("t2_data_len", flen_a[fb + 3], 88);

        // real samples, full guard and overwritten pending command
        sv_b = 1'b1; sd_b = 8'h55;
        tick();
        sv_b = 1'b0;
        check("t3_idle_discard", fill_b, 0);
        fb = flen_b.size(); bb = bits_b.size(); d0 = dones_b;
        rdy_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sv_b = 1'b1; sd_b = vals[i];
            tick();
        end
        sv_b = 1'b0;
        check("t3_fill_cap", fill_b, 4);
        for (int i = 0; i < 300 && dones_b == d0; i++) tick();
        repeat (2) tick();
        check("t3_done", dones_b - d0, 1);
        check("t3_frames", flen_b.size() - fb, 3);
        if (flen_b.size() - fb >= 3) begin
            check("t3_len2", flen_b[fb + 2], 40);
            pos = bb;
            check("t3_cmd_a", word_b(pos, 8), 2);    pos += 8;
            check("t3_cmd_b", word_b(pos, 8), 4);    pos += 8;
            check("t3_cmd_data", word_b(pos, 8), 7); pos += 8;
            for (int w = 0; w < 4; w++) begin
                check($sformatf("t3_word%0d", w), word_b(pos, 8), vals[w]);
                pos += 8;
            end
        end

        // abort mid data word
        d0 = dones_b;
        rdy_b = 1'b0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv_b = 1'b1; sd_b = 8'h11 * (i + 1);
            tick();
        end
        sv_b = 1'b0;
        wait_state_b(2, 200, "t4_standby");
        peer_b = 1'b1;
        tick();
        peer_b = 1'b0;
        repeat (11) tick();
        check("t4_mid_frame", frm_b, 1);
        check("t4_mid_bit", dat_b, 0);
        peer_b = 1'b1;
        tick();
        peer_b = 1'b0;
        check("t4_frame_drop", frm_b, 0);
        check("t4_fill", fill_b, 0);
        check("t4_state", state_b, 0);
        repeat (4) tick();
        check("t4_no_done", dones_b - d0, 0);

        // asynchronous reset during transfer, then a clean rerun
        rdy_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_state_a(3, 400, "t5_transfer");
        repeat (12) tick();
        #2 rst = 1'b0;
        #1;
        check("t5_async_state", state_a, 0);
        check("t5_async_fill", fill_a, 0);
        check("t5_async_ser", {en_a, dat_a, frm_a, done_a}, 0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_post_state", state_a, 0);
        scan_full_a("t5");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
